// File: rtl/qei_multi.sv
// Multi-channel quadrature encoder interface with filtered inputs, index capture and an Avalon-MM register map.
// Optional velocity measurement is built in when QEI_VELOCITY_EN is defined.
module qei_multi #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FILT_W     = 4,
  parameter int unsigned VEL_PERIOD = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3*NUM_CH-1:0]   enc_abz,
  input  logic [7:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic                  err_irq
);

  localparam int unsigned NP       = 3 * NUM_CH;
  localparam int unsigned FCW      = 4;
  localparam int unsigned WCW      = 5;
  localparam int unsigned WARM_LEN = 2 + FILT_W;
  localparam int unsigned NWORDS   = 4 * NUM_CH;

  // Gray position of an {A,B} pair along the forward sequence 00->10->11->01
  function automatic logic [1:0] quad_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_idx = 2'd0;
      2'b10:   quad_idx = 2'd1;
      2'b11:   quad_idx = 2'd2;
      default: quad_idx = 2'd3;
    endcase
  endfunction

  logic [NP-1:0]    sync1, sync2, filt, filt_q;
  logic [FCW-1:0]   fcnt [NP];
  logic [WCW-1:0]   warm_cnt;
  logic             warming;

  logic [CNT_W-1:0] pos     [NUM_CH];
  logic [CNT_W-1:0] idx_reg [NUM_CH];
  logic [1:0]       status  [NUM_CH];

  logic [NUM_CH-1:0] cnt_up, cnt_dn, ill_set, z_rise, pos_wr, st_wr;
  logic              wr_hit, rd_hit, err_any;
  logic [31:0]       rd_data;

  assign warming = (warm_cnt != WCW'(WARM_LEN));
  assign wr_hit  = avs_write && (avs_address < 8'(NWORDS));
  assign rd_hit  = (avs_address < 8'(NWORDS));

  // Synchronizers, stability filters and warm-up tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      filt     <= '0;
      filt_q   <= '0;
      warm_cnt <= '0;
      for (int i = 0; i < NP; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= enc_abz;
      sync2  <= sync1;
      filt_q <= warming ? sync2 : filt;
      if (warming) warm_cnt <= warm_cnt + WCW'(1);
      for (int i = 0; i < NP; i++) begin
        if (warming) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FCW'(FILT_W - 1)) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FCW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // Quadrature decode and bus write decode
  always_comb begin
    cnt_up  = '0;
    cnt_dn  = '0;
    ill_set = '0;
    z_rise  = '0;
    pos_wr  = '0;
    st_wr   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!warming) begin
        ill_set[k] = (filt[3*k+2] != filt_q[3*k+2]) && (filt[3*k+1] != filt_q[3*k+1]);
        cnt_up[k]  = quad_idx({filt[3*k+2], filt[3*k+1]}) ==
                     quad_idx({filt_q[3*k+2], filt_q[3*k+1]}) + 2'd1;
        cnt_dn[k]  = quad_idx({filt_q[3*k+2], filt_q[3*k+1]}) ==
                     quad_idx({filt[3*k+2], filt[3*k+1]}) + 2'd1;
        z_rise[k]  = filt[3*k] & ~filt_q[3*k];
      end
      pos_wr[k] = wr_hit && (avs_address[7:2] == 6'(k)) && (avs_address[1:0] == 2'd0);
      st_wr[k]  = wr_hit && (avs_address[7:2] == 6'(k)) && (avs_address[1:0] == 2'd2);
    end
  end

  // Per-channel position, index and sticky status; a bus write beats a count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        pos[k]     <= '0;
        idx_reg[k] <= '0;
        status[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pos_wr[k])      pos[k] <= avs_writedata[CNT_W-1:0];
        else if (cnt_up[k]) pos[k] <= pos[k] + CNT_W'(1);
        else if (cnt_dn[k]) pos[k] <= pos[k] - CNT_W'(1);
        if (z_rise[k]) idx_reg[k] <= pos[k];
        status[k] <= (status[k] & ~(st_wr[k] ? avs_writedata[1:0] : 2'b00)) |
                     {z_rise[k], ill_set[k]};
      end
    end
  end

`ifdef QEI_VELOCITY_EN
  localparam int unsigned VCW = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;

  logic [VCW-1:0]   vel_cnt;
  logic [CNT_W-1:0] vel  [NUM_CH];
  logic [CNT_W-1:0] snap [NUM_CH];

  // Window counter; each wrap latches the position delta over the last window
  always_ff @(posedge clk) begin
    if (reset) begin
      vel_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        vel[k]  <= '0;
        snap[k] <= '0;
      end
    end else if (vel_cnt == VCW'(VEL_PERIOD - 1)) begin
      vel_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        vel[k]  <= pos[k] - snap[k];
        snap[k] <= pos[k];
      end
    end else begin
      vel_cnt <= vel_cnt + VCW'(1);
    end
  end
`endif

  // Read mux and interrupt source
  always_comb begin
    rd_data = '0;
    err_any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      err_any = err_any | status[k][0];
      if (rd_hit && (avs_address[7:2] == 6'(k))) begin
        case (avs_address[1:0])
          2'd0:    rd_data = 32'(pos[k]);
          2'd1:    rd_data = 32'(idx_reg[k]);
          2'd2:    rd_data = {30'd0, status[k]};
`ifdef QEI_VELOCITY_EN
          default: rd_data = 32'($signed(vel[k]));
`else
          default: rd_data = '0;
`endif
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
      err_irq      <= 1'b0;
    end else begin
      if (avs_read) avs_readdata <= rd_data;
      err_irq <= err_any;
    end
  end

endmodule
